// File: rtl/pmm_sequencer.sv
// Host-side sequencer for a pattern-match memory (PMM): configuration writes, scan reset,
// and per-character lookups over a four-phase valid/ready handshake with timeout.
module pmm_sequencer #(
  parameter int TIMEOUT = 255,
  parameter int DEPTH   = 517
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic [10:0] cfg_addr,
  input  logic [63:0] cfg_data,
  input  logic        start,
  input  logic        chr_valid,
  output logic        chr_ready,
  input  logic [7:0]  chr_data,
  input  logic        chr_last,
  output logic [63:0] pmm_data,
  output logic [15:0] pmm_control,
  output logic        pmm_valid,
  input  logic        pmm_ready,
  input  logic        pmm_accepted,
  output logic        busy,
  output logic        done,
  output logic [15:0] match_count,
  output logic [15:0] first_pos,
  output logic        err
);

  localparam int PW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [PW-1:0] TMO_LAST = PW'(TIMEOUT - 1);
  localparam logic [11:0]   DEPTH_L  = 12'(DEPTH);

  typedef enum logic [2:0] {IDLE, CFG, RST, FETCH, ACK, REL} state_t;
  typedef enum logic [1:0] {OP_CFG, OP_RST, OP_CHR} op_t;

  state_t        state, state_d;
  op_t           op;
  logic          last_q;
  logic [15:0]   pos;
  logic [PW-1:0] phase_cnt;

  logic ld_cfg, ld_rst, ld_chr, bad_cfg, set_vld, clr_vld, clr_phase, chr_end, tmo, fin_done;

  assign cfg_ready = rst_n && (state == IDLE);
  assign chr_ready = (state == FETCH);
  assign busy      = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  always_comb begin
    state_d   = state;
    ld_cfg    = 1'b0;
    ld_rst    = 1'b0;
    ld_chr    = 1'b0;
    bad_cfg   = 1'b0;
    set_vld   = 1'b0;
    clr_vld   = 1'b0;
    clr_phase = 1'b0;
    chr_end   = 1'b0;
    tmo       = 1'b0;
    fin_done  = 1'b0;
    case (state)
      IDLE: begin
        // A config beat always wins over start; out-of-range addresses are swallowed.
        if (cfg_valid) begin
          if ({1'b0, cfg_addr} >= DEPTH_L) bad_cfg = 1'b1;
          else begin
            ld_cfg  = 1'b1;
            state_d = CFG;
          end
        end else if (start) begin
          ld_rst  = 1'b1;
          state_d = RST;
        end
      end
      CFG, RST: begin
        set_vld   = 1'b1;
        clr_phase = 1'b1;
        state_d   = ACK;
      end
      FETCH: begin
        if (chr_valid) begin
          ld_chr    = 1'b1;
          set_vld   = 1'b1;
          clr_phase = 1'b1;
          state_d   = ACK;
        end
      end
      ACK: begin
        if (pmm_ready) begin
          clr_vld   = 1'b1;
          clr_phase = 1'b1;
          chr_end   = (op == OP_CHR);
          state_d   = REL;
        end else if (phase_cnt == TMO_LAST) begin
          tmo     = 1'b1;
          clr_vld = 1'b1;
          state_d = IDLE;
        end
      end
      REL: begin
        if (!pmm_ready) begin
          case (op)
            OP_RST:  state_d = FETCH;
            OP_CHR: begin
              state_d  = last_q ? IDLE : FETCH;
              fin_done = last_q;
            end
            default: state_d = IDLE;
          endcase
        end else if (phase_cnt == TMO_LAST) begin
          tmo     = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pmm_valid   <= 1'b0;
      pmm_control <= '0;
      pmm_data    <= '0;
      done        <= 1'b0;
      match_count <= '0;
      first_pos   <= 16'hFFFF;
      err         <= 1'b0;
      pos         <= '0;
      op          <= OP_CFG;
      last_q      <= 1'b0;
      phase_cnt   <= '0;
    end else begin
      done <= fin_done;
      if (set_vld)      pmm_valid <= 1'b1;
      else if (clr_vld) pmm_valid <= 1'b0;
      if (ld_cfg) begin
        pmm_control <= {2'b01, cfg_addr, 3'b000};
        pmm_data    <= cfg_data;
        op          <= OP_CFG;
      end
      if (ld_rst) begin
        pmm_control <= {2'b11, 11'd0, 3'b000};
        pmm_data    <= '0;
        op          <= OP_RST;
        match_count <= '0;
        first_pos   <= 16'hFFFF;
        pos         <= '0;
        err         <= 1'b0;
      end
      if (ld_chr) begin
        pmm_control <= {2'b10, 11'd0, 3'b000};
        pmm_data    <= {56'd0, chr_data};
        op          <= OP_CHR;
        last_q      <= chr_last;
      end
      // Match bookkeeping uses the pre-increment position.
      if (chr_end) begin
        pos <= pos + 16'd1;
        if (pmm_accepted) begin
          if (match_count != 16'hFFFF) match_count <= match_count + 16'd1;
          if (first_pos == 16'hFFFF)   first_pos   <= pos;
        end
      end
      if (bad_cfg || tmo) err <= 1'b1;
      if (clr_phase)                          phase_cnt <= '0;
      else if (state == ACK || state == REL)  phase_cnt <= phase_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pmm_sequencer.sv
// Scoreboard bench for pmm_sequencer: expected PMM ops queued at stimulus time, popped on pmm_valid rise.
module tb_pmm_sequencer;
  localparam int TIMEOUT = 20;
  localparam int DEPTH   = 517;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cfg_valid, cfg_ready;
  logic [10:0] cfg_addr;
  logic [63:0] cfg_data;
  logic        start;
  logic        chr_valid, chr_ready, chr_last;
  logic [7:0]  chr_data;
  logic [63:0] pmm_data;
  logic [15:0] pmm_control;
  logic        pmm_valid, pmm_ready, pmm_accepted;
  logic        busy, done, err;
  logic [15:0] match_count, first_pos;

  int vectors = 0;
  int miscompares = 0;
  int done_cnt = 0;
  bit resp_en = 1'b1;
  logic [79:0] exp_q[$];

  pmm_sequencer #(.TIMEOUT(TIMEOUT), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_addr(cfg_addr), .cfg_data(cfg_data), .start(start),
    .chr_valid(chr_valid), .chr_ready(chr_ready), .chr_data(chr_data), .chr_last(chr_last),
    .pmm_data(pmm_data), .pmm_control(pmm_control), .pmm_valid(pmm_valid),
    .pmm_ready(pmm_ready), .pmm_accepted(pmm_accepted), .busy(busy), .done(done),
    .match_count(match_count), .first_pos(first_pos), .err(err)
  );

  always #5 clk = ~clk;

  // PMM model: raise ready one cycle after valid, accept characters >= 'b'.
  initial begin
    pmm_ready = 1'b0;
    pmm_accepted = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      if (!resp_en) begin
        pmm_ready = 1'b0;
        pmm_accepted = 1'b0;
      end else if (pmm_valid && !pmm_ready) begin
        pmm_ready = 1'b1;
        pmm_accepted = (pmm_control[15:14] == 2'b10) && (pmm_data[7:0] >= 8'h62);
      end else if (!pmm_valid && pmm_ready) begin
        pmm_ready = 1'b0;
        pmm_accepted = 1'b0;
      end
    end
  end

  // Op monitor: every new PMM request must match the next scoreboard entry and stay stable.
  logic        prev_vld = 1'b0;
  logic [79:0] prev_op;
  always @(negedge clk) begin
    if (done) done_cnt++;
    if (pmm_valid && !prev_vld) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_op got=%h expected none", {pmm_control, pmm_data});
      end else begin
        logic [79:0] e;
        e = exp_q.pop_front();
        if ({pmm_control, pmm_data} !== e) begin
          miscompares++;
          $display("FAIL pmm_op got=%h expected=%h", {pmm_control, pmm_data}, e);
        end
      end
    end else if (pmm_valid && prev_vld) begin
      vectors++;
      if ({pmm_control, pmm_data} !== prev_op) begin
        miscompares++;
        $display("FAIL op_stable got=%h expected=%h", {pmm_control, pmm_data}, prev_op);
      end
    end
    prev_vld = pmm_valid;
    prev_op  = {pmm_control, pmm_data};
  end

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < TIMEOUT * 4 + 50) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (busy) begin
      miscompares++;
      $display("FAIL %s_idle_timeout got busy=1 expected busy=0", name);
    end
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [10:0] a, input logic [63:0] d, input bit with_start);
    @(negedge clk);
    cfg_valid = 1'b1; cfg_addr = a; cfg_data = d; start = with_start;
    chk("cfg_ready_idle", 64'(cfg_ready), 64'd1);
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_pmm_valid", 64'(pmm_valid), 64'd0);
    chk("rst_pmm_control", 64'(pmm_control), 64'd0);
    chk("rst_pmm_data", pmm_data, 64'd0);
    chk("rst_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rst_chr_ready", 64'(chr_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_match", 64'(match_count), 64'd0);
    chk("rst_first", 64'(first_pos), 64'hFFFF);
    chk("rst_err", 64'(err), 64'd0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_cfg_ready", 64'(cfg_ready), 64'd1);
  endtask

  task automatic test_cfg;
    int d0 = done_cnt;
    exp_q.push_back({16'h5018, 64'h1});
    cfg_write(11'd515, 64'h1, 1'b0);
    chk("cfg_busy", 64'(busy), 64'd1);
    chk("cfg_ready_busy", 64'(cfg_ready), 64'd0);
    chk("cfg_chr_ready", 64'(chr_ready), 64'd0);
    wait_idle("cfg");
    chk("cfg_q_empty", 64'(exp_q.size()), 64'd0);
    chk("cfg_no_done", 64'(done_cnt - d0), 64'd0);
    chk("cfg_err", 64'(err), 64'd0);
  endtask

  task automatic run_scan(input string s);
    int d0 = done_cnt;
    int em = 0;
    int ef = 16'hFFFF;
    exp_q.push_back({16'hC000, 64'd0});
    for (int i = 0; i < s.len(); i++) begin
      byte c;
      c = s[i];
      exp_q.push_back({16'h8000, 56'd0, c});
      if (c >= 8'h62) begin
        em++;
        if (ef == 16'hFFFF) ef = i;
      end
    end
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < s.len(); i++) begin
      int n = 0;
      chr_valid = 1'b1; chr_data = s[i]; chr_last = (i == s.len() - 1);
      while (!chr_ready && n < 100) begin
        @(negedge clk);
        n++;
      end
      vectors++;
      if (!chr_ready) begin
        miscompares++;
        $display("FAIL scan_chr_ready got=0 expected=1 at char %0d", i);
      end
      @(negedge clk);
      chr_valid = 1'b0;
    end
    wait_idle("scan");
    chk("scan_match", 64'(match_count), 64'(em));
    chk("scan_first", 64'(first_pos), 64'(ef));
    chk("scan_done", 64'(done_cnt - d0), 64'd1);
    chk("scan_err", 64'(err), 64'd0);
    chk("scan_q_empty", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic test_scan;
    run_scan("abc");
    run_scan("aaqa");
    run_scan("aa");
  endtask

  task automatic test_bad_addr;
    bit saw_vld = 1'b0;
    cfg_write(11'd600, 64'hDEAD, 1'b0);
    repeat (4) begin
      if (pmm_valid || busy) saw_vld = 1'b1;
      @(negedge clk);
    end
    chk("bad_no_op", 64'(saw_vld), 64'd0);
    chk("bad_err", 64'(err), 64'd1);
    chk("bad_busy", 64'(busy), 64'd0);
  endtask

  task automatic test_timeout;
    int d0 = done_cnt;
    resp_en = 1'b0;
    exp_q.push_back({16'h4000 | 16'(3 << 3), 64'h55});
    cfg_write(11'd3, 64'h55, 1'b0);
    wait_idle("tmo");
    chk("tmo_valid", 64'(pmm_valid), 64'd0);
    chk("tmo_err", 64'(err), 64'd1);
    chk("tmo_busy", 64'(busy), 64'd0);
    chk("tmo_no_done", 64'(done_cnt - d0), 64'd0);
    chk("tmo_q_empty", 64'(exp_q.size()), 64'd0);
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_cfg_start;
    int d0 = done_cnt;
    exp_q.push_back({16'h4000 | 16'(7 << 3), 64'hA5A5});
    cfg_write(11'd7, 64'hA5A5, 1'b1);
    wait_idle("cs");
    repeat (3) @(negedge clk);
    chk("cs_busy", 64'(busy), 64'd0);
    chk("cs_q_empty", 64'(exp_q.size()), 64'd0);
    chk("cs_no_done", 64'(done_cnt - d0), 64'd0);
    chk("cs_err_kept", 64'(err), 64'd1);
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt;
    int n = 0;
    exp_q.push_back({16'hC000, 64'd0});
    exp_q.push_back({16'h8000, 64'h62});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (!chr_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    resp_en = 1'b0;
    chr_valid = 1'b1; chr_data = 8'h62; chr_last = 1'b1;
    @(negedge clk);
    chr_valid = 1'b0;
    @(negedge clk);
    chk("rm_in_ack", 64'(pmm_valid), 64'd1);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rm_pmm_valid", 64'(pmm_valid), 64'd0);
    chk("rm_pmm_control", 64'(pmm_control), 64'd0);
    chk("rm_pmm_data", pmm_data, 64'd0);
    chk("rm_cfg_ready", 64'(cfg_ready), 64'd0);
    chk("rm_chr_ready", 64'(chr_ready), 64'd0);
    chk("rm_busy", 64'(busy), 64'd0);
    chk("rm_match", 64'(match_count), 64'd0);
    chk("rm_first", 64'(first_pos), 64'hFFFF);
    chk("rm_err", 64'(err), 64'd0);
    chk("rm_no_done", 64'(done_cnt - d0), 64'd0);
    chk("rm_q_empty", 64'(exp_q.size()), 64'd0);
    rst_n = 1'b1;
    resp_en = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0; cfg_valid = 1'b0; cfg_addr = '0; cfg_data = '0; start = 1'b0;
    chr_valid = 1'b0; chr_data = '0; chr_last = 1'b0;
    test_reset;
    test_cfg;
    test_scan;
    test_bad_addr;
    run_scan("bb");
    test_timeout;
    test_cfg_start;
    test_reset_mid;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
